// File: rtl/addsub_pkg.sv
// Shared constants, FSM state type and sizing helpers for the serial adder/subtractor.
package addsub_pkg;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  // Number of BUSY cycles needed to sweep all WIDTH bits, DIGIT at a time.
  function automatic int ncyc(input int width, input int digit);
    return width / digit;
  endfunction

  // Digit counter width; sized to hold the value NCYC.
  function automatic int cnt_w(input int width, input int digit);
    return $clog2(width / digit + 1);
  endfunction

endpackage

// File: rtl/addsub_digit.sv
// Combinational DIGIT-bit ripple-carry slice. It also exposes the carry into
// its top bit, so the caller can derive signed overflow on the final digit.
module addsub_digit #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             cout,
  output logic             c_msb_in
);

  logic c;

  // Ripple the carry through the slice LSB first.
  always_comb begin
    s        = '0;
    c        = cin;
    c_msb_in = cin;
    for (int i = 0; i < DIGIT; i++) begin
      if (i == DIGIT - 1) c_msb_in = c;
      s[i] = x[i] ^ y[i] ^ c;
      c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/serial_addsub.sv
// Digit-serial A+B / A-B engine with valid/ready handshakes on both sides.
// Subtraction is computed as A + ~B + 1: B is inverted at capture and the
// carry register is preloaded with 1.
module serial_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow
);

  localparam int NCYC = ncyc(WIDTH, DIGIT);
  localparam int CW   = cnt_w(WIDTH, DIGIT);

  state_t                 state;
  logic [WIDTH-1:0]       a_sr;
  logic [WIDTH-1:0]       b_sr;
  logic [WIDTH-1:0]       res_sr;
  logic                   cy;
  logic                   mode_q;
  logic [CW-1:0]          cnt;

  logic [DIGIT-1:0]       s;
  logic                   cout;
  logic                   c_msb_in;
  logic [WIDTH+DIGIT-1:0] res_cat;
  logic [WIDTH-1:0]       res_next;
  logic                   last;

  addsub_digit #(.DIGIT(DIGIT)) u_digit (
    .x        (a_sr[DIGIT-1:0]),
    .y        (b_sr[DIGIT-1:0]),
    .cin      (cy),
    .s        (s),
    .cout     (cout),
    .c_msb_in (c_msb_in)
  );

  // New digit enters the result register from the MSB side; the concat form
  // stays legal even when DIGIT == WIDTH.
  assign res_cat  = {s, res_sr};
  assign res_next = res_cat[WIDTH+DIGIT-1:DIGIT];
  assign last     = (cnt == CW'(NCYC - 1));

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // FSM, operand shift registers, digit counter and result capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      a_sr     <= '0;
      b_sr     <= '0;
      res_sr   <= '0;
      cy       <= 1'b0;
      mode_q   <= 1'b0;
      cnt      <= '0;
      result   <= '0;
      carry    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sr   <= a;
            b_sr   <= (mode == MODE_SUB) ? ~b : b;
            mode_q <= mode;
            cy     <= mode;
            cnt    <= '0;
            state  <= BUSY;
          end
        end
        BUSY: begin
          a_sr   <= a_sr >> DIGIT;
          b_sr   <= b_sr >> DIGIT;
          res_sr <= res_next;
          cy     <= cout;
          cnt    <= cnt + 1'b1;
          if (last) begin
            // Outputs only move here, so they hold the last completed op
            // through IDLE and BUSY.
            result   <= res_next;
            carry    <= cout ^ mode_q;
            overflow <= c_msb_in ^ cout;
            state    <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_addsub.sv
// Scoreboard bench for serial_addsub: one instance at DIGIT=1, one at DIGIT=4.
module tb_serial_addsub;
  import addsub_pkg::*;

  typedef struct {
    logic [7:0] r;
    logic       c;
    logic       o;
    int         acc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       iv1, ir1, md1, ov1, or1, c1, o1;
  logic [7:0] a1, b1, r1;
  logic       iv4, ir4, md4, ov4, or4, c4, o4;
  logic [7:0] a4, b4, r4;

  exp_t q1[$];
  exp_t q4[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   rnd1 = 1'b0;
  bit   b2b = 1'b0;
  bit   pv1 = 1'b0;
  bit   pv4 = 1'b0;
  int   last_acc4 = -1;

  serial_addsub #(.WIDTH(8), .DIGIT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .mode(md1),
    .a(a1), .b(b1), .out_valid(ov1), .out_ready(or1), .result(r1),
    .carry(c1), .overflow(o1)
  );

  serial_addsub #(.WIDTH(8), .DIGIT(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .mode(md4),
    .a(a4), .b(b4), .out_valid(ov4), .out_ready(or4), .result(r4),
    .carry(c4), .overflow(o4)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  // Reference: plain integer arithmetic, unsigned for carry/borrow, signed for overflow.
  function automatic exp_t model(input logic m, input logic [7:0] x, input logic [7:0] y);
    exp_t e;
    int ua, ub, sa, sb, u, s;
    ua = int'(x);
    ub = int'(y);
    sa = int'($signed(x));
    sb = int'($signed(y));
    if (m == MODE_SUB) begin
      u   = ua - ub;
      s   = sa - sb;
      e.c = (ua < ub);
    end else begin
      u   = ua + ub;
      s   = sa + sb;
      e.c = (u > 255);
    end
    e.r   = 8'(u);
    e.o   = (s > 127) || (s < -128);
    e.acc = 0;
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int which, input logic m, input logic [7:0] x,
                       input logic [7:0] y, output exp_t e);
    int t;
    t = 0;
    e = model(m, x, y);
    if (which == 1) begin
      iv1 = 1'b1; md1 = m; a1 = x; b1 = y;
      while (!ir1 && t < 200) begin step(); t++; end
    end else begin
      iv4 = 1'b1; md4 = m; a4 = x; b4 = y;
      while (!ir4 && t < 200) begin step(); t++; end
    end
    if (t >= 200) begin
      chk("issue_timeout", t, 0);
      iv1 = 1'b0;
      iv4 = 1'b0;
      return;
    end
    e.acc = cyc + 1;
    if (which == 1) q1.push_back(e);
    else begin
      q4.push_back(e);
      if (b2b && last_acc4 >= 0) chk("d4_issue_interval", e.acc - last_acc4, 4);
      last_acc4 = e.acc;
    end
    step();
    if (which == 1) iv1 = 1'b0;
    else iv4 = 1'b0;
  endtask

  task automatic drain(input int which);
    int t;
    t = 0;
    while (((which == 1) ? q1.size() : q4.size()) != 0 && t < 300) begin
      step();
      t++;
    end
    if (t >= 300) begin
      chk("drain_timeout", (which == 1) ? q1.size() : q4.size(), 0);
      if (which == 1) q1.delete();
      else q4.delete();
    end
  endtask

  // Monitor for the DIGIT=1 instance.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) pv1 = 1'b0;
    else begin
      if (ov1) chk("d1_in_ready_in_done", ir1, 0);
      if (ov1 && !pv1) begin
        if (q1.size() == 0) chk("d1_unexpected_valid", q1.size(), 1);
        else chk("d1_latency", cyc - q1[0].acc, 8);
      end
      if (ov1 && or1 && q1.size() != 0) begin
        e = q1.pop_front();
        chk("d1_result", r1, e.r);
        chk("d1_carry", c1, e.c);
        chk("d1_overflow", o1, e.o);
      end
      pv1 = ov1;
    end
  end

  // Monitor for the DIGIT=4 instance.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) pv4 = 1'b0;
    else begin
      if (ov4) chk("d4_in_ready_in_done", ir4, 0);
      if (ov4 && !pv4) begin
        if (q4.size() == 0) chk("d4_unexpected_valid", q4.size(), 1);
        else chk("d4_latency", cyc - q4[0].acc, 2);
      end
      if (ov4 && or4 && q4.size() != 0) begin
        e = q4.pop_front();
        chk("d4_result", r4, e.r);
        chk("d4_carry", c4, e.c);
        chk("d4_overflow", o4, e.o);
      end
      pv4 = ov4;
    end
  end

  // Random consumer backpressure for the DIGIT=1 instance when enabled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd1) or1 = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    exp_t e;
    int   t;
    iv1 = 0; md1 = 0; a1 = 0; b1 = 0; or1 = 1;
    iv4 = 0; md4 = 0; a4 = 0; b4 = 0; or4 = 1;

    // Reset state
    #3;
    chk("rst_in_ready", ir1, 1);
    chk("rst_out_valid", ov1, 0);
    chk("rst_result", r1, 0);
    chk("rst_carry", c1, 0);
    chk("rst_overflow", o1, 0);
    chk("rst_d4_in_ready", ir4, 1);
    chk("rst_d4_out_valid", ov4, 0);
    step();
    step();
    rst_n = 1'b1;
    step();

    // Directed vectors, one at a time so latency is checked each time
    issue(1, MODE_ADD, 8'h3C, 8'h05, e); drain(1);
    issue(1, MODE_ADD, 8'hFF, 8'h01, e); drain(1);
    issue(1, MODE_ADD, 8'h7F, 8'h01, e); drain(1);
    issue(1, MODE_SUB, 8'h05, 8'h07, e); drain(1);
    issue(1, MODE_SUB, 8'h80, 8'h01, e); drain(1);

    // Backpressure: hold out_ready low while DONE, wiggle the inputs
    or1 = 1'b0;
    issue(1, MODE_ADD, 8'hA5, 8'h3C, e);
    t = 0;
    while (!ov1 && t < 50) begin step(); t++; end
    chk("bp_reached_done", ov1, 1);
    repeat (5) begin
      chk("bp_in_ready", ir1, 0);
      chk("bp_out_valid", ov1, 1);
      chk("bp_result", r1, e.r);
      chk("bp_carry", c1, e.c);
      chk("bp_overflow", o1, e.o);
      iv1 = 1'($urandom_range(0, 1));
      md1 = 1'($urandom_range(0, 1));
      a1  = 8'($urandom);
      b1  = 8'($urandom);
      step();
    end
    chk("bp_result_end", r1, e.r);
    iv1 = 1'b1;
    or1 = 1'b1;
    chk("bp_no_accept_in_done", ir1, 0);
    step();
    iv1 = 1'b0;
    chk("bp_in_ready_after", ir1, 1);
    chk("bp_out_valid_after", ov1, 0);
    step();
    drain(1);

    // Reset in the 3rd BUSY cycle discards the operation
    issue(1, MODE_ADD, 8'h55, 8'h66, e);
    step();
    step();
    rst_n = 1'b0;
    q1.delete();
    #1;
    chk("midrst_out_valid", ov1, 0);
    chk("midrst_in_ready", ir1, 1);
    chk("midrst_result", r1, 0);
    chk("midrst_carry", c1, 0);
    chk("midrst_overflow", o1, 0);
    step();
    rst_n = 1'b1;
    repeat (12) step();
    chk("midrst_no_valid", ov1, 0);
    issue(1, MODE_ADD, 8'h10, 8'h20, e); drain(1);

    // Random operations with random consumer readiness
    rnd1 = 1'b1;
    repeat (20) begin
      issue(1, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), e);
    end
    drain(1);
    rnd1 = 1'b0;
    step();
    or1 = 1'b1;
    step();

    // DIGIT=4: directed borrow case, then back-to-back issue
    issue(4, MODE_SUB, 8'h00, 8'h01, e); drain(4);
    b2b = 1'b1;
    last_acc4 = -1;
    repeat (8) begin
      issue(4, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), e);
      iv4 = 1'b1;
    end
    iv4 = 1'b0;
    drain(4);
    b2b = 1'b0;
    repeat (4) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
